// File: rtl/sequenciador_display.sv
// sequenciador_display: shows a note letter, then its value, then holds the value
// until the next sample; drives the 7-segment converter inputs and scan restart.
module sequenciador_display #(
    parameter int T_LETRA  = 25000000,
    parameter int T_NUMERO = 25000000,
    parameter int W        = 25
) (
    input  logic       clock,
    input  logic       zera_as_n,
    input  logic       valido,
    input  logic [4:0] nota_in,
    input  logic [7:0] valor_in,
    input  logic       apaga,
    output logic       pronto,
    output logic [7:0] numero,
    output logic [4:0] letra,
    output logic       select,
    output logic       zera_contador_display,
    output logic [1:0] db_estado
);
    typedef enum logic [1:0] {OCIOSO = 2'b00, LETRA = 2'b01, NUMERO = 2'b10, MANTEM = 2'b11} estado_t;

    estado_t      state_q, state_d;
    logic [W-1:0] timer_q, timer_d;
    logic [7:0]   numero_q, numero_d;
    logic [4:0]   letra_q, letra_d;
    logic         select_q, select_d;
    logic         pulse_q, pulse_d;

    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            state_q  <= OCIOSO;
            timer_q  <= '0;
            numero_q <= '0;
            letra_q  <= 5'd31;
            select_q <= 1'b1;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            numero_q <= numero_d;
            letra_q  <= letra_d;
            select_q <= select_d;
            pulse_q  <= pulse_d;
        end
    end

    // Blanking outranks both a pending sample and the phase timer.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        numero_d = numero_q;
        letra_d  = letra_q;
        select_d = select_q;
        pulse_d  = 1'b0;
        if (apaga) begin
            state_d  = OCIOSO;
            timer_d  = '0;
            numero_d = '0;
            letra_d  = 5'd31;
            select_d = 1'b1;
        end else begin
            case (state_q)
                OCIOSO, MANTEM: if (valido) begin
                    state_d  = LETRA;
                    timer_d  = '0;
                    numero_d = valor_in;
                    letra_d  = nota_in;
                    select_d = 1'b1;
                    pulse_d  = 1'b1;
                end
                LETRA: if (timer_q == W'(T_LETRA - 1)) begin
                    state_d  = NUMERO;
                    timer_d  = '0;
                    select_d = 1'b0;
                    pulse_d  = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
                NUMERO: if (timer_q == W'(T_NUMERO - 1)) begin
                    state_d = MANTEM;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
                default: state_d = OCIOSO;
            endcase
        end
    end

    assign pronto                = (state_q == OCIOSO) || (state_q == MANTEM);
    assign numero                = numero_q;
    assign letra                 = letra_q;
    assign select                = select_q;
    assign zera_contador_display = pulse_q;
    assign db_estado             = state_q;
endmodule

// File: tb/tb_sequenciador_display.sv
// tb_sequenciador_display: directed checks of the display sequencer with
// T_LETRA=4/T_NUMERO=3 (dut) and T_LETRA=1/T_NUMERO=3 (dut1) sharing stimulus.
module tb_sequenciador_display;
    logic       clock = 1'b0;
    logic       zera_as_n, valido, apaga;
    logic [4:0] nota_in;
    logic [7:0] valor_in;
    logic       pronto, select, pulse;
    logic [7:0] numero;
    logic [4:0] letra;
    logic [1:0] db_estado;
    logic       pronto1, select1, pulse1;
    logic [7:0] numero1;
    logic [4:0] letra1;
    logic [1:0] db_estado1;
    int checks = 0;
    int errors = 0;

    sequenciador_display #(.T_LETRA(4), .T_NUMERO(3), .W(3)) dut (
        .clock(clock), .zera_as_n(zera_as_n), .valido(valido), .nota_in(nota_in),
        .valor_in(valor_in), .apaga(apaga), .pronto(pronto), .numero(numero),
        .letra(letra), .select(select), .zera_contador_display(pulse), .db_estado(db_estado)
    );

    sequenciador_display #(.T_LETRA(1), .T_NUMERO(3), .W(3)) dut1 (
        .clock(clock), .zera_as_n(zera_as_n), .valido(valido), .nota_in(nota_in),
        .valor_in(valor_in), .apaga(apaga), .pronto(pronto1), .numero(numero1),
        .letra(letra1), .select(select1), .zera_contador_display(pulse1), .db_estado(db_estado1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic sel,
                           input logic pls, input logic [4:0] l, input logic [7:0] n);
        chk({tag, ".estado"}, 32'(db_estado), 32'(st));
        chk({tag, ".pronto"}, 32'(pronto), 32'(st == 2'b00 || st == 2'b11));
        chk({tag, ".select"}, 32'(select), 32'(sel));
        chk({tag, ".pulse"}, 32'(pulse), 32'(pls));
        chk({tag, ".letra"}, 32'(letra), 32'(l));
        chk({tag, ".numero"}, 32'(numero), 32'(n));
    endtask

    initial begin
        zera_as_n = 1'b0; valido = 1'b0; apaga = 1'b0; nota_in = '0; valor_in = '0;
        tick(); tick();
        chk_all("reset", 2'b00, 1'b1, 1'b0, 5'd31, 8'd0);
        zera_as_n = 1'b1;
        tick();
        chk_all("released", 2'b00, 1'b1, 1'b0, 5'd31, 8'd0);

        // single sample: cycles 1..4 letter, 5..7 number, 8+ hold
        valido = 1'b1; nota_in = 5'd5; valor_in = 8'd200;
        for (int c = 1; c <= 10; c++) begin
            tick();
            valido = 1'b0; nota_in = 5'd1; valor_in = 8'd1;
            chk_all($sformatf("single.c%0d", c), c <= 4 ? 2'b01 : (c <= 7 ? 2'b10 : 2'b11),
                    c <= 4, c == 1 || c == 5, 5'd5, 8'd200);
        end

        // valido held high: only the first MANTEM edge accepts
        valido = 1'b1; nota_in = 5'd7; valor_in = 8'd10;
        tick();
        chk_all("hold.acc", 2'b01, 1'b1, 1'b1, 5'd7, 8'd10);
        for (int c = 2; c <= 8; c++) begin
            nota_in = 5'(c + 10); valor_in = 8'(c + 100);
            tick();
            chk_all($sformatf("hold.c%0d", c), c <= 4 ? 2'b01 : (c <= 7 ? 2'b10 : 2'b11),
                    c <= 4, c == 5, 5'd7, 8'd10);
        end
        nota_in = 5'd20; valor_in = 8'd77;
        tick();
        chk_all("hold.reacc", 2'b01, 1'b1, 1'b1, 5'd20, 8'd77);

        // apaga during LETRA
        valido = 1'b0; apaga = 1'b1;
        tick();
        apaga = 1'b0;
        chk_all("apaga.letra", 2'b00, 1'b1, 1'b0, 5'd31, 8'd0);

        // apaga together with valido in MANTEM drops the sample
        valido = 1'b1; nota_in = 5'd3; valor_in = 8'd33;
        tick();
        valido = 1'b0;
        repeat (7) tick();
        chk_all("mantem", 2'b11, 1'b0, 1'b0, 5'd3, 8'd33);
        valido = 1'b1; apaga = 1'b1; nota_in = 5'd4; valor_in = 8'd44;
        tick();
        valido = 1'b0; apaga = 1'b0;
        chk_all("apaga.mantem", 2'b00, 1'b1, 1'b0, 5'd31, 8'd0);
        tick();
        chk_all("apaga.idle", 2'b00, 1'b1, 1'b0, 5'd31, 8'd0);

        // async reset in NUMERO
        valido = 1'b1; nota_in = 5'd6; valor_in = 8'd66;
        tick();
        valido = 1'b0;
        repeat (4) tick();
        chk_all("numero", 2'b10, 1'b0, 1'b1, 5'd6, 8'd66);
        #2 zera_as_n = 1'b0;
        #1 chk_all("async", 2'b00, 1'b1, 1'b0, 5'd31, 8'd0);
        tick();
        zera_as_n = 1'b1; valido = 1'b1; nota_in = 5'd8; valor_in = 8'd88;
        tick();
        valido = 1'b0;
        chk_all("after.reset", 2'b01, 1'b1, 1'b1, 5'd8, 8'd88);

        // T_LETRA=1 instance: pulses on two consecutive cycles, one letter cycle
        zera_as_n = 1'b0;
        tick();
        zera_as_n = 1'b1;
        tick();
        chk("min.idle.estado", 32'(db_estado1), 32'd0);
        valido = 1'b1; nota_in = 5'd2; valor_in = 8'd22;
        for (int c = 1; c <= 5; c++) begin
            tick();
            valido = 1'b0;
            chk($sformatf("min.c%0d.select", c), 32'(select1), 32'(c == 1));
            chk($sformatf("min.c%0d.pulse", c), 32'(pulse1), 32'(c <= 2));
            chk($sformatf("min.c%0d.estado", c), 32'(db_estado1),
                32'(c == 1 ? 2'b01 : (c <= 4 ? 2'b10 : 2'b11)));
            chk($sformatf("min.c%0d.pronto", c), 32'(pronto1), 32'(c == 5));
        end
        chk("min.letra", 32'(letra1), 32'd2);
        chk("min.numero", 32'(numero1), 32'd22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
